// File: rtl/clock_set_ctrl.sv
// Purpose : button-driven view/edit sequencer for the clock display path (time/date
//           view select, field-edit FSM, display muxing, commit strobes to the counters).
// Ports   : clk/rst_n (sync active-low); btn_mode/btn_next/btn_up debounced levels;
//           cur_* live BCD counter values in; smh_dmy/dem_chinh/blink_led display control,
//           disp_* digits to show, run_en counter enable, load_time/load_date one-cycle
//           strobes qualifying ld_* committed BCD values.
// Latency : every control output and ld_* is registered and changes on the edge that
//           sees the button event; disp_* follows cur_* combinationally outside EDIT.
module clock_set_ctrl #(
    parameter int TIMEOUT = 500000000,
    parameter int TW      = 29
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_mode,
    input  logic        btn_next,
    input  logic        btn_up,
    input  logic [7:0]  cur_ss,
    input  logic [7:0]  cur_mm,
    input  logic [7:0]  cur_hh,
    input  logic [7:0]  cur_dd,
    input  logic [7:0]  cur_mo,
    input  logic [15:0] cur_yyyy,
    output logic        smh_dmy,
    output logic        dem_chinh,
    output logic [1:0]  blink_led,
    output logic [7:0]  disp_ss,
    output logic [7:0]  disp_mm,
    output logic [7:0]  disp_hh,
    output logic [7:0]  disp_dd,
    output logic [7:0]  disp_mo,
    output logic [15:0] disp_yyyy,
    output logic        run_en,
    output logic        load_time,
    output logic        load_date,
    output logic [7:0]  ld_ss,
    output logic [7:0]  ld_mm,
    output logic [7:0]  ld_hh,
    output logic [7:0]  ld_dd,
    output logic [7:0]  ld_mo,
    output logic [15:0] ld_yyyy
);

    // RUN_* are the two idle views; each EDIT_* state names the field being edited.
    typedef enum logic [2:0] {
        S_RUN_T   = 3'd0,
        S_RUN_D   = 3'd1,
        S_EDIT_HH = 3'd2,
        S_EDIT_MM = 3'd3,
        S_EDIT_SS = 3'd4,
        S_EDIT_DD = 3'd5,
        S_EDIT_MO = 3'd6,
        S_EDIT_YY = 3'd7
    } state_t;

    // ------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------

    // Two-digit BCD increment that wraps from max_v back to min_v.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] v,
                                            input logic [7:0] max_v,
                                            input logic [7:0] min_v);
        logic [7:0] r;
        if (v >= max_v) begin
            r = min_v;
        end else if (v[3:0] >= 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Four-digit BCD increment with ripple carry; 9999 rolls to 0000.
    function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] >= 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Divisibility by 4 of a two-digit BCD value, decided from the digits directly:
    // even tens need units 0/4/8, odd tens need units 2/6.
    function automatic logic bcd2_div4(input logic [7:0] v);
        logic r;
        if (!v[4]) begin
            r = (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
        end else begin
            r = (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t         state_q;
    logic           mode_prev_q, next_prev_q, up_prev_q;
    logic           smh_dmy_q, dem_chinh_q, run_en_q;
    logic [1:0]     blink_q;
    logic           load_time_q, load_date_q;
    logic [7:0]     e_ss_q, e_mm_q, e_hh_q, e_dd_q, e_mo_q;
    logic [15:0]    e_yy_q;
    logic [7:0]     ld_ss_q, ld_mm_q, ld_hh_q, ld_dd_q, ld_mo_q;
    logic [15:0]    ld_yy_q;
    logic [TW-1:0]  idle_q;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic ev_mode, ev_next, ev_up, any_ev;
    logic in_edit, timeout_d, abort_d;

    assign ev_mode = btn_mode & ~mode_prev_q;
    assign ev_next = btn_next & ~next_prev_q;
    assign ev_up   = btn_up   & ~up_prev_q;
    assign any_ev  = ev_mode | ev_next | ev_up;

    assign in_edit   = (state_q != S_RUN_T) && (state_q != S_RUN_D);
    // Any button activity, even one dropped by priority, counts as non-idle.
    assign timeout_d = in_edit && !any_ev && (idle_q == TW'(TIMEOUT - 1));
    assign abort_d   = in_edit && (ev_mode || timeout_d);

    // ------------------------------------------------------------------
    // Day clamp applied on date commit
    // ------------------------------------------------------------------
    logic       leap_d;
    logic [7:0] dim_d;
    logic [7:0] dd_clamp_d;

    // Century years (low digits 00) are leap only when the high digits divide by 4.
    assign leap_d = (e_yy_q[7:0] != 8'h00) ? bcd2_div4(e_yy_q[7:0])
                                            : bcd2_div4(e_yy_q[15:8]);

    always_comb begin
        dim_d = 8'h31;
        case (e_mo_q)
            8'h04, 8'h06, 8'h09, 8'h11: dim_d = 8'h30;
            8'h02:                      dim_d = leap_d ? 8'h29 : 8'h28;
            default:                    dim_d = 8'h31;
        endcase
    end

    // Valid BCD compares correctly as plain binary.
    assign dd_clamp_d = (e_dd_q > dim_d) ? dim_d : e_dd_q;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_RUN_T;
            // History regs reset high so a button held through reset cannot fire.
            mode_prev_q <= 1'b1;
            next_prev_q <= 1'b1;
            up_prev_q   <= 1'b1;
            smh_dmy_q   <= 1'b0;
            dem_chinh_q <= 1'b0;
            run_en_q    <= 1'b1;
            blink_q     <= 2'b00;
            load_time_q <= 1'b0;
            load_date_q <= 1'b0;
            e_ss_q      <= 8'h00;
            e_mm_q      <= 8'h00;
            e_hh_q      <= 8'h00;
            e_dd_q      <= 8'h00;
            e_mo_q      <= 8'h00;
            e_yy_q      <= 16'h0000;
            ld_ss_q     <= 8'h00;
            ld_mm_q     <= 8'h00;
            ld_hh_q     <= 8'h00;
            ld_dd_q     <= 8'h00;
            ld_mo_q     <= 8'h00;
            ld_yy_q     <= 16'h0000;
            idle_q      <= '0;
        end else begin
            mode_prev_q <= btn_mode;
            next_prev_q <= btn_next;
            up_prev_q   <= btn_up;
            load_time_q <= 1'b0;
            load_date_q <= 1'b0;

            if (!in_edit || any_ev || timeout_d) begin
                idle_q <= '0;
            end else begin
                idle_q <= idle_q + 1'b1;
            end

            if (!in_edit) begin
                // Snapshot live values on entry so the first display frame in EDIT
                // matches what was on screen just before.
                if (ev_mode) begin
                    state_q   <= (state_q == S_RUN_T) ? S_RUN_D : S_RUN_T;
                    smh_dmy_q <= (state_q == S_RUN_T);
                end else if (ev_next) begin
                    e_ss_q      <= cur_ss;
                    e_mm_q      <= cur_mm;
                    e_hh_q      <= cur_hh;
                    e_dd_q      <= cur_dd;
                    e_mo_q      <= cur_mo;
                    e_yy_q      <= cur_yyyy;
                    dem_chinh_q <= 1'b1;
                    run_en_q    <= 1'b0;
                    if (state_q == S_RUN_T) begin
                        state_q <= S_EDIT_HH;
                        blink_q <= 2'b00;
                    end else begin
                        state_q <= S_EDIT_DD;
                        blink_q <= 2'b01;
                    end
                end
            end else if (abort_d) begin
                state_q     <= smh_dmy_q ? S_RUN_D : S_RUN_T;
                dem_chinh_q <= 1'b0;
                run_en_q    <= 1'b1;
                blink_q     <= 2'b00;
            end else if (ev_next) begin
                case (state_q)
                    S_EDIT_HH: begin state_q <= S_EDIT_MM; blink_q <= 2'b01; end
                    S_EDIT_MM: begin state_q <= S_EDIT_SS; blink_q <= 2'b10; end
                    S_EDIT_DD: begin state_q <= S_EDIT_MO; blink_q <= 2'b10; end
                    S_EDIT_MO: begin state_q <= S_EDIT_YY; blink_q <= 2'b11; end
                    S_EDIT_SS: begin
                        state_q     <= S_RUN_T;
                        ld_ss_q     <= e_ss_q;
                        ld_mm_q     <= e_mm_q;
                        ld_hh_q     <= e_hh_q;
                        load_time_q <= 1'b1;
                        dem_chinh_q <= 1'b0;
                        run_en_q    <= 1'b1;
                        blink_q     <= 2'b00;
                    end
                    S_EDIT_YY: begin
                        state_q     <= S_RUN_D;
                        ld_dd_q     <= dd_clamp_d;
                        ld_mo_q     <= e_mo_q;
                        ld_yy_q     <= e_yy_q;
                        load_date_q <= 1'b1;
                        dem_chinh_q <= 1'b0;
                        run_en_q    <= 1'b1;
                        blink_q     <= 2'b00;
                    end
                    default: state_q <= state_q;
                endcase
            end else if (ev_up) begin
                case (state_q)
                    S_EDIT_HH: e_hh_q <= bcd2_inc(e_hh_q, 8'h23, 8'h00);
                    S_EDIT_MM: e_mm_q <= bcd2_inc(e_mm_q, 8'h59, 8'h00);
                    S_EDIT_SS: e_ss_q <= bcd2_inc(e_ss_q, 8'h59, 8'h00);
                    S_EDIT_DD: e_dd_q <= bcd2_inc(e_dd_q, 8'h31, 8'h01);
                    S_EDIT_MO: e_mo_q <= bcd2_inc(e_mo_q, 8'h12, 8'h01);
                    S_EDIT_YY: e_yy_q <= bcd4_inc(e_yy_q);
                    default:   e_ss_q <= e_ss_q;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign smh_dmy   = smh_dmy_q;
    assign dem_chinh = dem_chinh_q;
    assign blink_led = blink_q;
    assign run_en    = run_en_q;
    assign load_time = load_time_q;
    assign load_date = load_date_q;
    assign ld_ss     = ld_ss_q;
    assign ld_mm     = ld_mm_q;
    assign ld_hh     = ld_hh_q;
    assign ld_dd     = ld_dd_q;
    assign ld_mo     = ld_mo_q;
    assign ld_yyyy   = ld_yy_q;

    // Selecting on the registered edit flag keeps the display switch aligned with dem_chinh.
    assign disp_ss   = dem_chinh_q ? e_ss_q : cur_ss;
    assign disp_mm   = dem_chinh_q ? e_mm_q : cur_mm;
    assign disp_hh   = dem_chinh_q ? e_hh_q : cur_hh;
    assign disp_dd   = dem_chinh_q ? e_dd_q : cur_dd;
    assign disp_mo   = dem_chinh_q ? e_mo_q : cur_mo;
    assign disp_yyyy = dem_chinh_q ? e_yy_q : cur_yyyy;

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_mode, btn_next, btn_up;
    logic [7:0]  cur_ss, cur_mm, cur_hh, cur_dd, cur_mo;
    logic [15:0] cur_yyyy;
    logic        smh_dmy, dem_chinh, run_en, load_time, load_date;
    logic [1:0]  blink_led;
    logic [7:0]  disp_ss, disp_mm, disp_hh, disp_dd, disp_mo;
    logic [15:0] disp_yyyy;
    logic [7:0]  ld_ss, ld_mm, ld_hh, ld_dd, ld_mo;
    logic [15:0] ld_yyyy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clock_set_ctrl #(.TIMEOUT(16), .TW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up),
        .cur_ss(cur_ss), .cur_mm(cur_mm), .cur_hh(cur_hh),
        .cur_dd(cur_dd), .cur_mo(cur_mo), .cur_yyyy(cur_yyyy),
        .smh_dmy(smh_dmy), .dem_chinh(dem_chinh), .blink_led(blink_led),
        .disp_ss(disp_ss), .disp_mm(disp_mm), .disp_hh(disp_hh),
        .disp_dd(disp_dd), .disp_mo(disp_mo), .disp_yyyy(disp_yyyy),
        .run_en(run_en), .load_time(load_time), .load_date(load_date),
        .ld_ss(ld_ss), .ld_mm(ld_mm), .ld_hh(ld_hh),
        .ld_dd(ld_dd), .ld_mo(ld_mo), .ld_yyyy(ld_yyyy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Button is raised at a falling edge, the event lands on the next rising edge,
    // and the task returns at the following falling edge with results visible.
    task automatic press(input bit m, input bit n, input bit u);
        @(negedge clk);
        btn_mode = m;
        btn_next = n;
        btn_up   = u;
        @(negedge clk);
        btn_mode = 1'b0;
        btn_next = 1'b0;
        btn_up   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        btn_mode = 1'b0;
        btn_next = 1'b1;
        btn_up   = 1'b0;
        cur_ss   = 8'h12;
        cur_mm   = 8'h45;
        cur_hh   = 8'h23;
        cur_dd   = 8'h31;
        cur_mo   = 8'h04;
        cur_yyyy = 16'h2023;

        // T1: reset values, and a button held through reset must not fire.
        idle(3);
        chk("rst_smh_dmy", smh_dmy, 0);
        chk("rst_dem_chinh", dem_chinh, 0);
        chk("rst_blink", blink_led, 0);
        chk("rst_run_en", run_en, 1);
        chk("rst_load_time", load_time, 0);
        chk("rst_load_date", load_date, 0);
        chk("rst_ld_hh", ld_hh, 0);
        chk("rst_ld_yyyy", ld_yyyy, 0);
        chk("rst_disp_hh_live", disp_hh, 8'h23);
        rst_n = 1'b1;
        idle(3);
        chk("held_next_no_event", dem_chinh, 0);
        btn_next = 1'b0;
        idle(2);
        chk("release_no_event", dem_chinh, 0);

        // T2: time edit, hour wraps 23->00, commit.
        press(0, 1, 0);
        chk("t2_enter_dem", dem_chinh, 1);
        chk("t2_enter_run_en", run_en, 0);
        chk("t2_enter_blink", blink_led, 2'b00);
        chk("t2_enter_disp_hh", disp_hh, 8'h23);
        press(0, 0, 1);
        chk("t2_hh_wrap", disp_hh, 8'h00);
        chk("t2_blink_hh", blink_led, 2'b00);
        press(0, 1, 0);
        chk("t2_blink_mm", blink_led, 2'b01);
        press(0, 1, 0);
        chk("t2_blink_ss", blink_led, 2'b10);
        press(0, 1, 0);
        chk("t2_load_time", load_time, 1);
        chk("t2_ld_hh", ld_hh, 8'h00);
        chk("t2_ld_mm", ld_mm, 8'h45);
        chk("t2_ld_ss", ld_ss, 8'h12);
        chk("t2_run_en", run_en, 1);
        chk("t2_dem_off", dem_chinh, 0);
        chk("t2_no_load_date", load_date, 0);
        idle(1);
        chk("t2_strobe_1cyc", load_time, 0);
        chk("t2_ld_hh_hold", ld_hh, 8'h00);

        // T3: date view, day wraps 31->01->02, then clamp 31 -> 30 in April.
        press(1, 0, 0);
        chk("t3_date_view", smh_dmy, 1);
        press(0, 1, 0);
        chk("t3_blink_dd", blink_led, 2'b01);
        chk("t3_disp_dd", disp_dd, 8'h31);
        press(0, 0, 1);
        chk("t3_dd_wrap", disp_dd, 8'h01);
        press(0, 0, 1);
        chk("t3_dd_02", disp_dd, 8'h02);
        press(0, 1, 0);
        chk("t3_blink_mo", blink_led, 2'b10);
        press(0, 1, 0);
        chk("t3_blink_yy", blink_led, 2'b11);
        press(0, 1, 0);
        chk("t3_load_date", load_date, 1);
        chk("t3_ld_dd", ld_dd, 8'h02);
        chk("t3_ld_mo", ld_mo, 8'h04);
        chk("t3_ld_yyyy", ld_yyyy, 16'h2023);
        chk("t3_stay_date", smh_dmy, 1);
        idle(1);
        chk("t3_strobe_1cyc", load_date, 0);
        repeat (4) press(0, 1, 0);
        chk("t3_clamp_load", load_date, 1);
        chk("t3_clamp_dd30", ld_dd, 8'h30);

        // T4: February clamp under the leap rules.
        cur_dd = 8'h30;
        cur_mo = 8'h02;
        cur_yyyy = 16'h2024;
        repeat (4) press(0, 1, 0);
        chk("t4_2024_dd", ld_dd, 8'h29);
        cur_yyyy = 16'h1900;
        repeat (4) press(0, 1, 0);
        chk("t4_1900_dd", ld_dd, 8'h28);
        cur_yyyy = 16'h2000;
        repeat (4) press(0, 1, 0);
        chk("t4_2000_dd", ld_dd, 8'h29);
        cur_yyyy = 16'h2023;
        repeat (4) press(0, 1, 0);
        chk("t4_2023_dd", ld_dd, 8'h28);
        chk("t4_2023_yyyy", ld_yyyy, 16'h2023);

        // T5: year rollover and month wrap, then MODE+UP together aborts.
        cur_mo = 8'h12;
        cur_yyyy = 16'h9999;
        press(0, 1, 0);
        press(0, 1, 0);
        press(0, 0, 1);
        chk("t5_mo_wrap", disp_mo, 8'h01);
        press(0, 1, 0);
        press(0, 0, 1);
        chk("t5_yyyy_wrap", disp_yyyy, 16'h0000);
        press(1, 0, 1);
        chk("t5_abort_dem", dem_chinh, 0);
        chk("t5_abort_no_load", load_date, 0);
        chk("t5_abort_view", smh_dmy, 1);
        chk("t5_abort_run_en", run_en, 1);
        chk("t5_abort_disp_live", disp_yyyy, 16'h9999);
        chk("t5_ld_yyyy_kept", ld_yyyy, 16'h2023);

        // T6: idle timeout after 16 cycles in EDIT, then reset mid-edit.
        press(1, 0, 0);
        chk("t6_time_view", smh_dmy, 0);
        press(0, 1, 0);
        chk("t6_enter", dem_chinh, 1);
        idle(15);
        chk("t6_before_timeout", dem_chinh, 1);
        idle(1);
        chk("t6_timeout_dem", dem_chinh, 0);
        chk("t6_timeout_no_load", load_time, 0);
        chk("t6_timeout_run_en", run_en, 1);
        press(0, 1, 0);
        press(0, 0, 1);
        chk("t6_edit_hh", disp_hh, 8'h00);
        rst_n = 1'b0;
        idle(1);
        chk("t6_rst_dem", dem_chinh, 0);
        chk("t6_rst_run_en", run_en, 1);
        chk("t6_rst_blink", blink_led, 0);
        chk("t6_rst_load", load_time, 0);
        chk("t6_rst_ld_hh", ld_hh, 0);
        chk("t6_rst_ld_dd", ld_dd, 0);
        chk("t6_rst_disp_live", disp_hh, 8'h23);
        rst_n = 1'b1;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
